// File: rtl/chacha_pkg.sv
// Shared constants for the ChaCha20 parameter server and block engine:
// chunk type codes, host config address map and ctrl/status bit positions.
package chacha_pkg;

  localparam logic [1:0] CT_KEY     = 2'd0;
  localparam logic [1:0] CT_NONCE   = 2'd1;
  localparam logic [1:0] CT_COUNTER = 2'd2;

  localparam logic [3:0] ADDR_KEY0   = 4'd0;
  localparam logic [3:0] ADDR_NONCE0 = 4'd8;
  localparam logic [3:0] ADDR_CTR    = 4'd11;
  localparam logic [3:0] ADDR_CTRL   = 4'd12;
  localparam logic [3:0] ADDR_STATUS = 4'd13;

  localparam int CTRL_AUTO_INC_BIT  = 0;
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_EXHAUST_BIT = 1;

endpackage

// File: rtl/chacha_param_regfile.sv
// Key/nonce/counter storage with the host config port and the block-counter
// incrementer; also provides a combinational word select for the chunk server.
module chacha_param_regfile
  import chacha_pkg::*;
#(
  parameter int KEY_WORDS    = 8,
  parameter int NONCE_WORDS  = 3,
  parameter bit AUTO_INC_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we_i,
  input  logic        cfg_re_i,
  input  logic [3:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  input  logic        eng_busy_i,
  input  logic        eng_done_i,
  input  logic [1:0]  sel_type_i,
  input  logic [4:0]  sel_idx_i,
  output logic [31:0] sel_word_o,
  output logic        exhausted_o,
  output logic [31:0] cfg_rdata_o,
  output logic        cfg_rvalid_o,
  output logic        host_err_o
);

  logic [31:0] key_q [KEY_WORDS];
  logic [31:0] key_d [KEY_WORDS];
  logic [31:0] nonce_q [NONCE_WORDS];
  logic [31:0] nonce_d [NONCE_WORDS];
  logic [31:0] ctr_q, ctr_d;
  logic        exh_q, exh_d;
  logic        auto_inc_q, auto_inc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;
  logic [31:0] rd_word;
  logic        wr_ok, wr_bad, rd_bad;

  // Writes are locked out while the engine is consuming parameters.
  assign wr_ok      = cfg_we_i && !eng_busy_i && (cfg_addr_i <= ADDR_CTRL);
  assign wr_bad     = cfg_we_i && !wr_ok;
  assign rd_bad     = cfg_re_i && (cfg_addr_i > ADDR_STATUS);
  assign host_err_o = wr_bad || rd_bad;

  always_comb begin
    key_d      = key_q;
    nonce_d    = nonce_q;
    auto_inc_d = auto_inc_q;
    for (int i = 0; i < KEY_WORDS; i++)
      if (wr_ok && cfg_addr_i == 4'(ADDR_KEY0 + i)) key_d[i] = cfg_wdata_i;
    for (int i = 0; i < NONCE_WORDS; i++)
      if (wr_ok && cfg_addr_i == 4'(ADDR_NONCE0 + i)) nonce_d[i] = cfg_wdata_i;
    if (wr_ok && cfg_addr_i == ADDR_CTRL) auto_inc_d = cfg_wdata_i[CTRL_AUTO_INC_BIT];
  end

  // A host counter write outranks a same-cycle auto-increment.
  always_comb begin
    ctr_d = ctr_q;
    exh_d = exh_q;
    if (wr_ok && cfg_addr_i == ADDR_CTR) begin
      ctr_d = cfg_wdata_i;
      exh_d = 1'b0;
    end else if (eng_done_i && auto_inc_q) begin
      ctr_d = ctr_q + 32'd1;
      if (ctr_q == 32'hFFFF_FFFF) exh_d = 1'b1;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < KEY_WORDS; i++)
      if (cfg_addr_i == 4'(ADDR_KEY0 + i)) rd_word = key_q[i];
    for (int i = 0; i < NONCE_WORDS; i++)
      if (cfg_addr_i == 4'(ADDR_NONCE0 + i)) rd_word = nonce_q[i];
    if (cfg_addr_i == ADDR_CTR)  rd_word = ctr_q;
    if (cfg_addr_i == ADDR_CTRL) rd_word[CTRL_AUTO_INC_BIT] = auto_inc_q;
    if (cfg_addr_i == ADDR_STATUS) begin
      rd_word[STATUS_BUSY_BIT]    = eng_busy_i;
      rd_word[STATUS_EXHAUST_BIT] = exh_q;
    end
    rdata_d = cfg_re_i ? rd_word : rdata_q;
  end

  always_comb begin
    sel_word_o = '0;
    case (sel_type_i)
      CT_KEY:
        for (int i = 0; i < KEY_WORDS; i++)
          if (sel_idx_i == 5'(i)) sel_word_o = key_q[i];
      CT_NONCE:
        for (int i = 0; i < NONCE_WORDS; i++)
          if (sel_idx_i == 5'(i)) sel_word_o = nonce_q[i];
      CT_COUNTER: sel_word_o = ctr_q;
      default:    sel_word_o = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KEY_WORDS; i++)   key_q[i]   <= '0;
      for (int i = 0; i < NONCE_WORDS; i++) nonce_q[i] <= '0;
      ctr_q      <= '0;
      exh_q      <= 1'b0;
      auto_inc_q <= AUTO_INC_RST;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      ctr_q      <= ctr_d;
      exh_q      <= exh_d;
      auto_inc_q <= auto_inc_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= cfg_re_i;
    end
  end

  assign exhausted_o  = exh_q;
  assign cfg_rdata_o  = rdata_q;
  assign cfg_rvalid_o = rvalid_q;

endmodule

// File: rtl/chacha_param_server.sv
// Parameter source for the ChaCha20 block engine: decodes chunk requests,
// drops duplicates and registers the one-cycle chunk response.
module chacha_param_server
  import chacha_pkg::*;
#(
  parameter int KEY_WORDS    = 8,
  parameter int NONCE_WORDS  = 3,
  parameter bit AUTO_INC_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic        cfg_re,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        cfg_rvalid,
  output logic        cfg_err,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic        chunk_request,
  input  logic [1:0]  request_type,
  input  logic [4:0]  chunk_index,
  output logic        chunk_valid,
  output logic [1:0]  chunk_type,
  output logic [31:0] chunk,
  output logic        ctr_exhausted
);

  logic [31:0] sel_word;
  logic        exhausted;
  logic        host_err;
  logic        in_range, live_req, accept, req_err;
  logic        vld_q, vld_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] chunk_q, chunk_d;
  logic        err_q, err_d;

  chacha_param_regfile #(
    .KEY_WORDS    (KEY_WORDS),
    .NONCE_WORDS  (NONCE_WORDS),
    .AUTO_INC_RST (AUTO_INC_RST)
  ) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .cfg_we_i     (cfg_we),
    .cfg_re_i     (cfg_re),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .eng_busy_i   (eng_busy),
    .eng_done_i   (eng_done),
    .sel_type_i   (request_type),
    .sel_idx_i    (chunk_index),
    .sel_word_o   (sel_word),
    .exhausted_o  (exhausted),
    .cfg_rdata_o  (cfg_rdata),
    .cfg_rvalid_o (cfg_rvalid),
    .host_err_o   (host_err)
  );

  always_comb begin
    case (request_type)
      CT_KEY:     in_range = chunk_index < 5'(KEY_WORDS);
      CT_NONCE:   in_range = chunk_index < 5'(NONCE_WORDS);
      CT_COUNTER: in_range = chunk_index == 5'd0;
      default:    in_range = 1'b0;
    endcase
  end

  // A request seen while a response is on the bus is the engine's re-assert; ignore it.
  assign live_req = chunk_request && !vld_q;
  // An exhausted counter stalls the engine silently until the host reloads it.
  assign accept   = live_req && in_range && !(request_type == CT_COUNTER && exhausted);
  assign req_err  = live_req && !in_range;

  always_comb begin
    vld_d   = accept;
    type_d  = accept ? request_type : type_q;
    chunk_d = accept ? sel_word : chunk_q;
    err_d   = host_err || req_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      type_q  <= '0;
      chunk_q <= '0;
      err_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      type_q  <= type_d;
      chunk_q <= chunk_d;
      err_q   <= err_d;
    end
  end

  assign chunk_valid   = vld_q;
  assign chunk_type    = type_q;
  assign chunk         = chunk_q;
  assign cfg_err       = err_q;
  assign ctr_exhausted = exhausted;

endmodule

// File: tb/tb_chacha_param_server.sv
// Directed bench for chacha_param_server: config port, chunk handshake,
// duplicate drop, counter auto-increment/exhaustion and reset cancellation.
module tb_chacha_param_server;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, cfg_re;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_rvalid, cfg_err;
  logic        eng_busy, eng_done;
  logic        chunk_request;
  logic [1:0]  request_type;
  logic [4:0]  chunk_index;
  logic        chunk_valid;
  logic [1:0]  chunk_type;
  logic [31:0] chunk;
  logic        ctr_exhausted;

  int checks = 0;
  int errors = 0;

  chacha_param_server dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_re        (cfg_re),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_rdata     (cfg_rdata),
    .cfg_rvalid    (cfg_rvalid),
    .cfg_err       (cfg_err),
    .eng_busy      (eng_busy),
    .eng_done      (eng_done),
    .chunk_request (chunk_request),
    .request_type  (request_type),
    .chunk_index   (chunk_index),
    .chunk_valid   (chunk_valid),
    .chunk_type    (chunk_type),
    .chunk         (chunk),
    .ctr_exhausted (ctr_exhausted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    cfg_re = 1'b1; cfg_addr = a;
    tick();
    cfg_re = 1'b0;
    chk({tag, "_rvalid"}, {31'b0, cfg_rvalid}, 32'd1);
    chk(tag, cfg_rdata, exp);
  endtask

  // Single-cycle request; checks the response that appears one cycle later.
  task automatic request(input string tag, input logic [1:0] t, input logic [4:0] idx,
                         input logic exp_vld, input logic [31:0] exp_word);
    chunk_request = 1'b1; request_type = t; chunk_index = idx;
    tick();
    chunk_request = 1'b0;
    chk({tag, "_valid"}, {31'b0, chunk_valid}, {31'b0, exp_vld});
    if (exp_vld) begin
      chk({tag, "_type"}, {30'b0, chunk_type}, {30'b0, t});
      chk({tag, "_word"}, chunk, exp_word);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    eng_busy = 1'b0; eng_done = 1'b0;
    chunk_request = 1'b0; request_type = '0; chunk_index = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_valid",  {31'b0, chunk_valid}, 32'd0);
    chk("rst_chunk",  chunk, 32'd0);
    chk("rst_err",    {31'b0, cfg_err}, 32'd0);
    chk("rst_rvalid", {31'b0, cfg_rvalid}, 32'd0);
    chk("rst_exh",    {31'b0, ctr_exhausted}, 32'd0);
    cfg_read("rst_ctrl", 4'd12, 32'd1);
    cfg_read("rst_key5", 4'd5, 32'd0);

    // 1: load parameters, serve key word 3
    for (int i = 0; i < 8; i++) cfg_write(4'(i), 32'(8'h11 * (i + 1)));
    cfg_write(4'd8, 32'hA);
    cfg_write(4'd9, 32'hB);
    cfg_write(4'd10, 32'hC);
    cfg_write(4'd11, 32'd5);
    chk("wr_noerr", {31'b0, cfg_err}, 32'd0);
    request("t1_key3", 2'd0, 5'd3, 1'b1, 32'h44);
    chk("t1_hold_valid", {31'b0, chunk_valid}, 32'd0);
    chk("t1_hold_chunk", chunk, 32'h44);
    cfg_read("t1_rd_nonce1", 4'd9, 32'hB);
    cfg_read("t1_rd_key7", 4'd7, 32'h88);

    // 2: request held two cycles -> only one response
    chunk_request = 1'b1; request_type = 2'd1; chunk_index = 5'd0;
    tick();
    chk("t2_first_valid", {31'b0, chunk_valid}, 32'd1);
    chk("t2_first_word", chunk, 32'hA);
    tick();
    chunk_request = 1'b0;
    chk("t2_dup_dropped", {31'b0, chunk_valid}, 32'd0);
    tick();
    chk("t2_idle", {31'b0, chunk_valid}, 32'd0);
    request("t2_nonce2", 2'd1, 5'd2, 1'b1, 32'hC);

    // 3: counter wrap sets exhausted; stall until rewritten
    cfg_write(4'd11, 32'hFFFF_FFFF);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("t3_exh_set", {31'b0, ctr_exhausted}, 32'd1);
    cfg_read("t3_ctr_wrapped", 4'd11, 32'd0);
    cfg_read("t3_status", 4'd13, 32'd2);
    request("t3_stall", 2'd2, 5'd0, 1'b0, 32'd0);
    chk("t3_stall_noerr", {31'b0, cfg_err}, 32'd0);
    cfg_write(4'd11, 32'd7);
    chk("t3_exh_clr", {31'b0, ctr_exhausted}, 32'd0);
    request("t3_ctr7", 2'd2, 5'd0, 1'b1, 32'd7);

    // 4: busy lockout and bad addresses
    eng_busy = 1'b1;
    cfg_write(4'd0, 32'hDEAD);
    chk("t4_busy_err", {31'b0, cfg_err}, 32'd1);
    tick();
    chk("t4_err_pulse", {31'b0, cfg_err}, 32'd0);
    cfg_read("t4_status_busy", 4'd13, 32'd1);
    eng_busy = 1'b0;
    cfg_read("t4_key0_kept", 4'd0, 32'h11);
    cfg_write(4'd0, 32'hDEAD);
    chk("t4_wr_ok", {31'b0, cfg_err}, 32'd0);
    cfg_read("t4_key0_new", 4'd0, 32'hDEAD);
    cfg_write(4'd13, 32'h3);
    chk("t4_ro_err", {31'b0, cfg_err}, 32'd1);
    cfg_read("t4_bad_rd", 4'd14, 32'd0);
    chk("t4_bad_rd_err", {31'b0, cfg_err}, 32'd1);

    // 5: write beats increment; out-of-range requests
    cfg_we = 1'b1; cfg_addr = 4'd11; cfg_wdata = 32'h100; eng_done = 1'b1;
    tick();
    cfg_we = 1'b0; eng_done = 1'b0;
    cfg_read("t5_ctr_write_wins", 4'd11, 32'h100);
    request("t5_key9", 2'd0, 5'd9, 1'b0, 32'd0);
    chunk_request = 1'b1; request_type = 2'd0; chunk_index = 5'd9;
    tick();
    chunk_request = 1'b0;
    chk("t5_key9_err", {31'b0, cfg_err}, 32'd1);
    tick();
    chunk_request = 1'b1; request_type = 2'd3; chunk_index = 5'd0;
    tick();
    chunk_request = 1'b0;
    chk("t5_type3_valid", {31'b0, chunk_valid}, 32'd0);
    chk("t5_type3_err", {31'b0, cfg_err}, 32'd1);
    tick();
    request("t5_ctr_idx1", 2'd2, 5'd1, 1'b0, 32'd0);

    // 6: back-to-back blocks with consecutive counters
    cfg_write(4'd11, 32'd5);
    for (int b = 0; b < 3; b++) begin
      eng_busy = 1'b1;
      request("t6_key1", 2'd0, 5'd1, 1'b1, 32'h22);
      request("t6_nonce0", 2'd1, 5'd0, 1'b1, 32'hA);
      request("t6_ctr", 2'd2, 5'd0, 1'b1, 32'(5 + b));
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0; eng_busy = 1'b0;
    end
    cfg_read("t6_ctr_after", 4'd11, 32'd8);
    cfg_write(4'd12, 32'd0);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    cfg_read("t6_no_autoinc", 4'd11, 32'd8);

    // rst asserted with a request pending
    chunk_request = 1'b1; request_type = 2'd0; chunk_index = 5'd1; rst = 1'b1;
    tick();
    rst = 1'b0; chunk_request = 1'b0;
    chk("t6_rst_valid", {31'b0, chunk_valid}, 32'd0);
    tick();
    chk("t6_after_rst_valid", {31'b0, chunk_valid}, 32'd0);
    cfg_read("t6_rst_key1", 4'd1, 32'd0);
    cfg_read("t6_rst_ctrl", 4'd12, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
